// File: rtl/alu_iter_if.sv
// alu_iter_if: request/result handshake bundle for the alu_iter execute stage.
//
// Signals (named from the ALU's point of view):
//   flush      abort of any in-flight or held operation (issue side drives)
//   in_valid   operation request            in_ready   ALU can accept
//   op[4:0]    operation code               a, b[N-1:0] operands
//   out_valid  result/zero/err valid        out_ready  writeback accepts
//   result     operation result             zero       compare flag
//   err        illegal or disabled opcode
//
// Modports:
//   master  issue/writeback side (drives requests, consumes results)
//   slave   the ALU itself
interface alu_iter_if #(
    parameter int N = 64
);
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;
    logic         err;

    modport master (
        output flush, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, err
    );

    modport slave (
        input  flush, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, err
    );
endinterface

// File: rtl/alu_iter.sv
// alu_iter: execute-stage ALU with valid/ready handshake.
//
// Single-cycle ops (add/sub/logic/shift/compare, illegal opcodes and divide
// special cases) are accepted straight into DONE. Multiply, divide and
// remainder iterate one bit per cycle for N cycles plus one sign fix-up cycle.
// The result is held in DONE until out_ready; flush drops everything.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_iter_if.slave (flush, in_valid/in_ready, op, a, b,
//        out_valid/out_ready, result, zero, err)
//
// Configuration macro:
//   ALU_ITER_MULDIV_EN  when defined, opcodes 0x10-0x16 (MUL, MULH, MULHU,
//                       DIV, DIVU, REM, REMU) and the iterative datapath are
//                       built; otherwise those opcodes report err=1.
module alu_iter #(
    parameter int N = 64
) (
    input logic       clk,
    input logic       rst,
    alu_iter_if.slave bus
);
    localparam int SW = $clog2(N);

    typedef enum logic [4:0] {
        OP_ADD   = 5'h01,
        OP_SUB   = 5'h02,
        OP_AND   = 5'h03,
        OP_OR    = 5'h04,
        OP_XOR   = 5'h05,
        OP_SLL   = 5'h06,
        OP_SRL   = 5'h07,
        OP_SRA   = 5'h08,
        OP_EQ    = 5'h09,
        OP_NE    = 5'h0A,
        OP_LEU   = 5'h0B,
        OP_LTU   = 5'h0C,
        OP_GEU   = 5'h0D,
        OP_GTU   = 5'h0E,
        OP_LT    = 5'h0F,
        OP_MUL   = 5'h10,
        OP_MULH  = 5'h11,
        OP_MULHU = 5'h12,
        OP_DIV   = 5'h13,
        OP_DIVU  = 5'h14,
        OP_REM   = 5'h15,
        OP_REMU  = 5'h16
    } op_e;

`ifdef ALU_ITER_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};
`else
    typedef enum logic {S_IDLE, S_DONE} state_e;
`endif

    state_e       state_q, state_d;
    logic [N-1:0] result_q, result_d;
    logic         zero_q, zero_d;
    logic         err_q, err_d;

    // Decode of the incoming request (single-cycle result and routing).
    logic [N-1:0] sc_result;
    logic         sc_zero;
    logic         sc_err;
    logic         cmp;
    logic         flag;
    logic [SW-1:0] sh;

`ifdef ALU_ITER_MULDIV_EN
    logic            go_mul;
    logic            go_div;
    logic            a_sgn, b_sgn;
    logic [N-1:0]    a_mag, b_mag;

    logic [4:0]      op_q, op_d;
    logic            neg_q, neg_d;      // quotient/product must be negated
    logic            dneg_q, dneg_d;    // dividend was negative (remainder sign)
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]  acc_q, acc_d;      // product accumulator
    logic [2*N-1:0]  mcand_q, mcand_d;  // multiplicand, shifted left each step
    logic [N-1:0]    mplier_q, mplier_d;// multiplier, shifted right each step
    logic [N-1:0]    rem_q, rem_d;      // partial remainder
    logic [N-1:0]    quo_q, quo_d;      // dividend bits out, quotient bits in
    logic [N-1:0]    dvs_q, dvs_d;      // divisor magnitude

    logic [2*N-1:0]  prod;
    logic [N:0]      rem_shift;
    logic [N:0]      diff;
    logic [N-1:0]    quo_fix;
    logic [N-1:0]    rem_fix;
`endif

    always_comb begin
        sh        = bus.b[SW-1:0];
        sc_result = '0;
        sc_err    = 1'b0;
        cmp       = 1'b0;
        flag      = 1'b0;
`ifdef ALU_ITER_MULDIV_EN
        go_mul    = 1'b0;
        go_div    = 1'b0;
        // Only MULH, DIV and REM work on signed magnitudes.
        a_sgn     = (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM) && bus.a[N-1];
        b_sgn     = (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM) && bus.b[N-1];
        a_mag     = a_sgn ? -bus.a : bus.a;
        b_mag     = b_sgn ? -bus.b : bus.b;
`endif
        case (bus.op)
            OP_ADD:  sc_result = bus.a + bus.b;
            OP_SUB:  sc_result = bus.a - bus.b;
            OP_AND:  sc_result = bus.a & bus.b;
            OP_OR:   sc_result = bus.a | bus.b;
            OP_XOR:  sc_result = bus.a ^ bus.b;
            OP_SLL:  sc_result = bus.a << sh;
            OP_SRL:  sc_result = bus.a >> sh;
            OP_SRA:  sc_result = $signed(bus.a) >>> sh;
            OP_EQ:   begin cmp = 1'b1; flag = (bus.a == bus.b); end
            OP_NE:   begin cmp = 1'b1; flag = (bus.a != bus.b); end
            OP_LEU:  begin cmp = 1'b1; flag = (bus.a <= bus.b); end
            OP_LTU:  begin cmp = 1'b1; flag = (bus.a <  bus.b); end
            OP_GEU:  begin cmp = 1'b1; flag = (bus.a >= bus.b); end
            OP_GTU:  begin cmp = 1'b1; flag = (bus.a >  bus.b); end
            OP_LT:   begin cmp = 1'b1; flag = ($signed(bus.a) < $signed(bus.b)); end
`ifdef ALU_ITER_MULDIV_EN
            OP_MUL, OP_MULH, OP_MULHU: go_mul = 1'b1;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                // Divide-by-zero and signed overflow finish immediately.
                if (bus.b == '0) begin
                    sc_result = (bus.op == OP_DIV || bus.op == OP_DIVU) ? '1 : bus.a;
                end else if ((bus.op == OP_DIV || bus.op == OP_REM) &&
                             bus.a == MIN_VAL && bus.b == '1) begin
                    sc_result = (bus.op == OP_DIV) ? MIN_VAL : '0;
                end else begin
                    go_div = 1'b1;
                end
            end
`endif
            default: sc_err = 1'b1;
        endcase
        if (cmp) begin
            sc_result = {{(N-1){1'b0}}, flag};
        end
        sc_zero = cmp & flag;
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
`ifdef ALU_ITER_MULDIV_EN
        op_d      = op_q;
        neg_d     = neg_q;
        dneg_d    = dneg_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        prod      = '0;
        rem_shift = {rem_q, quo_q[N-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        quo_fix   = neg_q ? -quo_q : quo_q;
        rem_fix   = dneg_q ? -rem_q : rem_q;
`endif
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
`ifdef ALU_ITER_MULDIV_EN
                        op_d = bus.op;
                        if (go_mul) begin
                            state_d  = S_MUL;
                            acc_d    = '0;
                            mcand_d  = {{N{1'b0}}, a_mag};
                            mplier_d = b_mag;
                            neg_d    = a_sgn ^ b_sgn;
                            cnt_d    = CNT_W'(N);
                        end else if (go_div) begin
                            state_d = S_DIV;
                            rem_d   = '0;
                            quo_d   = a_mag;
                            dvs_d   = b_mag;
                            neg_d   = a_sgn ^ b_sgn;
                            dneg_d  = a_sgn;
                            cnt_d   = CNT_W'(N);
                        end else
`endif
                        begin
                            state_d  = S_DONE;
                            result_d = sc_result;
                            zero_d   = sc_zero;
                            err_d    = sc_err;
                        end
                    end
                end
`ifdef ALU_ITER_MULDIV_EN
                S_MUL: begin
                    if (cnt_q != '0) begin
                        if (mplier_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        cnt_d    = cnt_q - CNT_W'(1);
                    end else begin
                        prod     = neg_q ? -acc_q : acc_q;
                        result_d = (op_q == OP_MUL) ? prod[N-1:0] : prod[2*N-1:N];
                        zero_d   = 1'b0;
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                    end
                end
                S_DIV: begin
                    if (cnt_q != '0) begin
                        // diff[N] set means the trial subtraction went negative.
                        if (!diff[N]) begin
                            rem_d = diff[N-1:0];
                            quo_d = {quo_q[N-2:0], 1'b1};
                        end else begin
                            rem_d = rem_shift[N-1:0];
                            quo_d = {quo_q[N-2:0], 1'b0};
                        end
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        result_d = (op_q == OP_DIV || op_q == OP_DIVU) ? quo_fix : rem_fix;
                        zero_d   = 1'b0;
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

`ifdef ALU_ITER_MULDIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            dneg_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
        end else begin
            op_q     <= op_d;
            neg_q    <= neg_d;
            dneg_q   <= dneg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
        end
    end
`endif

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
endmodule
